// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults, read-mode constants and occupancy helper
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_PTR_WIDTH  = 3;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointers carry one wrap bit above the address, so occupancy is taken modulo 2^(ptr_width+1).
  function automatic logic [31:0] fifo_occupancy(input logic [31:0] wr_ptr,
                                                 input logic [31:0] rd_ptr,
                                                 input int unsigned ptr_width);
    logic [31:0] mask;
    mask = (32'd1 << (ptr_width + 1)) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PTR_WIDTH  = FIFO_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << PTR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO with registered flags, thresholds, error flags and FWFT mode
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = FIFO_DATA_WIDTH,
  parameter int PTR_WIDTH       = FIFO_PTR_WIDTH,
  parameter int DEPTH           = 1 << PTR_WIDTH,
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 1,
  parameter int FWFT            = FIFO_MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
    $error("synchronous_fifo: DEPTH must equal 1 << PTR_WIDTH");
  end

  localparam logic [PTR_WIDTH:0] AF_TH   = (PTR_WIDTH + 1)'(ALMOST_FULL_TH);
  localparam logic [PTR_WIDTH:0] AE_TH   = (PTR_WIDTH + 1)'(ALMOST_EMPTY_TH);
  localparam logic               IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  logic [PTR_WIDTH:0]    wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data, dout_q;

  // Acceptance uses only registered flags, keeping request inputs off every output path.
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  assign wr_ptr_nxt = wr_ptr + {{PTR_WIDTH{1'b0}}, wr_acc};
  assign rd_ptr_nxt = rd_ptr + {{PTR_WIDTH{1'b0}}, rd_acc};
  assign count_nxt  = (PTR_WIDTH + 1)'(fifo_occupancy(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PTR_WIDTH));

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[PTR_WIDTH-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[PTR_WIDTH-1:0]),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (wr_ptr_nxt == rd_ptr_nxt);
      full         <= (wr_ptr_nxt[PTR_WIDTH-1:0] == rd_ptr_nxt[PTR_WIDTH-1:0]) &&
                      (wr_ptr_nxt[PTR_WIDTH] != rd_ptr_nxt[PTR_WIDTH]);
      almost_empty <= (count_nxt <= AE_TH);
      almost_full  <= (count_nxt >= AF_TH);
    end
  end

  // Sticky errors: a new set condition beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  // In FWFT mode dout_q shadows the head so the last word stays visible once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (IS_FWFT ? !empty : rd_acc) begin
      dout_q <= rd_data;
    end
  end

  assign data_out = (IS_FWFT && !empty) ? rd_data : dout_q;

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - scoreboard bench for synchronous_fifo in standard and FWFT modes
module tb_synchronous_fifo;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [PW:0]   count;

  logic          fw_w_en = 1'b0, fw_r_en = 1'b0, fw_err_clr = 1'b0;
  logic [DW-1:0] fw_din = '0;
  logic [DW-1:0] fw_dout;
  logic          fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf;
  logic [PW:0]   fw_count;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  bit            m_ovf = 0, m_unf = 0;
  bit            pending = 0;

  always #5 clk = ~clk;

  synchronous_fifo #(
    .DATA_WIDTH(DW), .PTR_WIDTH(PW), .DEPTH(DEPTH),
    .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(1), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  synchronous_fifo #(
    .DATA_WIDTH(DW), .PTR_WIDTH(PW), .DEPTH(DEPTH),
    .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(1), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(fw_w_en), .r_en(fw_r_en), .data_in(fw_din),
    .err_clr(fw_err_clr), .data_out(fw_dout), .full(fw_full), .empty(fw_empty),
    .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
    .overflow(fw_ovf), .underflow(fw_unf)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a read accepted at an edge must show its word on data_out by the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (pending) begin
        if (exp_q.size() == 0) chk("sb_unexpected_read", 1, 0);
        else chk("sb_data_out", int'(data_out), int'(exp_q.pop_front()));
      end
      pending = rst_n && r_en && !empty;
    end
  end

  task automatic check_status(input string tag);
    int n;
    n = mq.size();
    chk({tag, "_count"}, int'(count), n);
    chk({tag, "_empty"}, int'(empty), int'(n == 0));
    chk({tag, "_full"}, int'(full), int'(n == DEPTH));
    chk({tag, "_afull"}, int'(almost_full), int'(n >= 6));
    chk({tag, "_aempty"}, int'(almost_empty), int'(n <= 1));
    chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    chk({tag, "_unf"}, int'(underflow), int'(m_unf));
    chk({tag, "_dout"}, int'(data_out), int'(last_rd));
  endtask

  // Called at posedge+1; drives one cycle, advances the model, checks state after the edge.
  task automatic step(input string tag, input bit w, input logic [DW-1:0] d, input bit r, input bit clr);
    bit wacc, racc;
    w_en = w; data_in = d; r_en = r; err_clr = clr;
    wacc = w && (mq.size() < DEPTH);
    racc = r && (mq.size() > 0);
    if (w && mq.size() == DEPTH) m_ovf = 1; else if (clr) m_ovf = 0;
    if (r && mq.size() == 0) m_unf = 1; else if (clr) m_unf = 0;
    if (racc) begin
      last_rd = mq.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wacc) mq.push_back(d);
    @(posedge clk); #1;
    w_en = 0; r_en = 0; err_clr = 0;
    check_status(tag);
  endtask

  task automatic fw_step(input bit w, input logic [DW-1:0] d, input bit r);
    fw_w_en = w; fw_din = d; fw_r_en = r;
    @(posedge clk); #1;
    fw_w_en = 0; fw_r_en = 0;
  endtask

  initial begin
    int sent, cyc;
    logic [DW-1:0] v3 [3];
    v3[0] = 8'h24; v3[1] = 8'h81; v3[2] = 8'h09;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_status("reset");

    for (int i = 0; i < 3; i++) step("wr3", 1, v3[i], 0, 0);
    for (int i = 0; i < 3; i++) step("rd3", 0, 0, 1, 0);
    step("idle", 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) step("fill", 1, DW'(i), 0, 0);
    step("wr_full", 1, 8'hAA, 0, 0);
    for (int i = 0; i < 8; i++) step("drain", 0, 0, 1, 0);
    step("clr1", 0, 0, 0, 1);

    step("rd_empty", 0, 0, 1, 0);
    step("clr2", 0, 0, 0, 1);
    step("unf_vs_clr", 0, 0, 1, 1);
    step("clr3", 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step("pre4", 1, DW'(8'h10 + i), 0, 0);
    step("both_at4", 1, 8'h14, 1, 0);
    for (int i = 0; i < 4; i++) step("post4", 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step("fill2", 1, DW'(8'h30 + i), 0, 0);
    step("both_full", 1, 8'hAA, 1, 0);
    for (int i = 0; i < 7; i++) step("drain2", 0, 0, 1, 0);
    step("both_empty", 1, 8'h77, 1, 0);
    step("drain3", 0, 0, 1, 0);
    step("clr4", 0, 0, 0, 1);

    sent = 0;
    cyc = 0;
    while ((sent < 40 || mq.size() > 0) && cyc < 2000) begin
      bit w, r;
      w = (sent < 40) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (w && mq.size() < DEPTH) sent++;
      step("stream", w, DW'($urandom), r, 0);
      cyc++;
    end
    chk("stream_complete", int'(sent == 40 && mq.size() == 0), 1);
    step("clr5", 0, 0, 0, 1);
    step("settle", 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) step("pre_rst", 1, DW'(8'hC0 + i), 0, 0);
    rst_n = 1'b0;
    #1;
    mq.delete(); exp_q.delete(); pending = 0;
    last_rd = '0; m_ovf = 0; m_unf = 0;
    check_status("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    step("post_rst_wr", 1, 8'h3C, 0, 0);
    step("post_rst_rd", 0, 0, 1, 0);
    step("post_rst_idle", 0, 0, 0, 0);

    fw_step(1, 8'h5A, 0);
    chk("fwft_empty_fall", int'(fw_empty), 0);
    chk("fwft_head", int'(fw_dout), 8'h5A);
    fw_step(0, 0, 0);
    chk("fwft_head_hold", int'(fw_dout), 8'h5A);
    fw_step(0, 0, 1);
    chk("fwft_pop_empty", int'(fw_empty), 1);
    chk("fwft_last_kept", int'(fw_dout), 8'h5A);
    fw_step(1, 8'h11, 0);
    fw_step(1, 8'h22, 0);
    chk("fwft_head2", int'(fw_dout), 8'h11);
    chk("fwft_count2", int'(fw_count), 2);
    fw_step(0, 0, 1);
    chk("fwft_next_head", int'(fw_dout), 8'h22);
    fw_step(0, 0, 1);
    chk("fwft_drained", int'(fw_empty), 1);
    chk("fwft_no_unf", int'(fw_unf), 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/synchronous_fifo.md
# synchronous_fifo

Single-clock, parametrised FIFO with registered status flags, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits alongside the asynchronous FIFO and is used wherever producer and consumer share one clock. Typical uses are pipeline elasticity and rate smoothing inside a single clock domain.

## Interface
- DATA_WIDTH, 8, word width in bits
- PTR_WIDTH, 3, address width; DEPTH = 1 << PTR_WIDTH
- DEPTH, 1 << PTR_WIDTH, number of entries; any other value is illegal
- ALMOST_FULL_TH, DEPTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH
- ALMOST_EMPTY_TH, 1, almost_empty asserts when count <= this value; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- w_en  in  1  write request
- r_en  in  1  read request (standard) / pop request (FWFT)
- data_in  in  DATA_WIDTH  write data, sampled with w_en
- err_clr  in  1  synchronous clear of overflow and underflow
- data_out  out  DATA_WIDTH  read data
- full, empty  out  1  registered status flags
- almost_full, almost_empty  out  1  registered threshold flags
- count  out  PTR_WIDTH+1  registered occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Read and write pointers are PTR_WIDTH+1 bits wide. The MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (addresses equal) && (wrap bits differ).
- A write is accepted iff w_en && !full, using the registered flag. An accepted write stores data_in at mem[wr_ptr[PTR_WIDTH-1:0]] and increments wr_ptr.
- A read is accepted iff r_en && !empty. An accepted read increments rd_ptr.
- When both are accepted in the same cycle, count is unchanged and both pointers advance.
- When full, a simultaneous w_en is rejected even if a read is accepted that cycle.
- When empty, a simultaneous r_en is rejected; the write is accepted.
- Standard mode (FWFT=0): data_out is a register loaded with mem[rd_ptr] on an accepted read. Otherwise it holds its value.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever !empty, so the head word is visible without a request. r_en pops the head. While empty, data_out holds its last value.
- count, full, empty, almost_full and almost_empty are all computed from the next-state pointers and registered.
- Arithmetic: count = wr_ptr - rd_ptr, computed modulo 2^(PTR_WIDTH+1).
- overflow sets on w_en && full. underflow sets on r_en && empty.
- Both error flags stay set until err_clr is asserted. If a set condition and err_clr occur in the same cycle, set wins.
- Rejected requests never change pointers, memory or data_out.

## Timing
- Reset values: empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0, data_out=0. Pointers are reset to 0; memory contents are not reset.
- Reset mid-operation: the FIFO returns to empty immediately (asynchronously). Data already stored is discarded.
- Write to flags: the first write into an empty FIFO deasserts empty and sets count=1 at the next edge.
- Standard read latency: data_out is valid on the edge after the accepted r_en, i.e. 1 cycle.
- FWFT read latency: the first word appears on data_out in the same cycle that empty deasserts, i.e. 1 cycle after the write.
- After the DEPTH-th write, full asserts at the next edge. One accepted read deasserts it at the edge after that read.
- Wrap-around: the pointer MSB toggles every DEPTH operations. Flags and count must remain correct across any number of wraps.
- No combinational path from w_en or r_en to any output.

## Structure
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and PTR_WIDTH;
  - read-mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1;
  - a function computing occupancy from two pointers, shared with the asynchronous FIFO.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array with synchronous write and asynchronous read, selected by address.
- The top level contains the pointers, flag logic, error flags and the mode-dependent output stage.

## Test plan
All scenarios use DEPTH=8, ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=1, FWFT=0 unless noted.
- Reset, then idle: empty=1, almost_empty=1, count=0, data_out=00 and all other flags 0. Write 24, 81, 09, then read three times: data_out shows 24, 81, 09, each one cycle after its r_en. Count goes 3→0.
- Write 00..07 back-to-back:
  - almost_empty drops when count=2;
  - almost_full rises when count=6;
  - full rises after the 8th write.
  - A 9th write of AA is rejected and overflow=1. Reading all 8 words returns 00..07, so AA never appears.
- Read while empty: underflow=1 and data_out is unchanged. Pulse err_clr: underflow=0. Assert err_clr in the same cycle as a new underflow: underflow stays 1.
- Simultaneous w_en/r_en:
  - at count=4: count stays 4 and output order is preserved;
  - when full: the read is accepted, the write is rejected, count=7 and overflow=1;
  - when empty: the write is accepted, the read is rejected, count=1 and underflow=1.
- FWFT=1: write 5A. data_out=5A when empty falls, with no r_en. Pop with r_en: empty=1 next cycle.
- Stream 40 words through with continuous, randomly gapped w_en/r_en, covering 5 pointer wraps. Every word comes out in order, and count always equals a scoreboard depth.
- Assert rst_n low while count=5: all outputs return to their reset values immediately. After reset, the first read after a new write returns the new word.
